virtio_notify_sched: RTL and testbench
======================================

Name: virtio_notify_sched

Overview:
- Scheduler between the virtio CSR block and the virtqueue processing engine.
- Takes driver Queue Notify events (writes to CSR offset 0x10) and keeps a pending bit per queue.
- Grants one queue at a time to the engine, round-robin, and waits for completion.
- On completion, raises a per-queue MSI-X request using the Queue MSIX Vector programmed at CSR 0x16.

Parameters:
- NUM_Q, 3, number of virtqueues; valid queue indices are 0..NUM_Q-1.
- QIDX_W, 16, width of queue index fields; matches the Queue Select / Queue Notify width.
- VEC_W, 16, MSI-X vector width.
- NO_VECTOR, 16'hFFFF, vector value meaning "no interrupt".

Ports:
- clk  in  1  single clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- notify_valid  in  1  one-cycle pulse: driver wrote Queue Notify
- notify_qidx  in  QIDX_W  queue index written to Queue Notify
- drv_ok  in  1  Device Status DRIVER_OK bit (status bit 2)
- q_en  in  NUM_Q  per-queue enable; 1 when the Queue Address is non-zero
- q_msix_vec  in  NUM_Q*VEC_W  Queue MSIX Vector per queue; queue i occupies bits [i*VEC_W +: VEC_W]
- svc_valid  out  1  service request to the engine
- svc_qidx  out  QIDX_W  queue being serviced
- svc_ready  in  1  engine accepts the request
- done_valid  in  1  one-cycle pulse: engine finished the granted queue
- done_irq  in  1  sampled with done_valid; 1 = used ring updated, interrupt needed
- irq_req  out  1  MSI-X request
- irq_vec  out  VEC_W  vector for irq_req
- irq_ack  in  1  MSI-X request consumed
- pending  out  NUM_Q  per-queue pending bits (status/debug)
- busy  out  1  high whenever the FSM is not IDLE
- drop_cnt  out  8  saturating count of ignored notifies

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, pending=0, rr_ptr=0, svc_valid=0, svc_qidx=0, irq_req=0, irq_vec=0, drop_cnt=0.
- All outputs are registered.
- Notify capture:
  - On a notify_valid cycle with notify_qidx<NUM_Q, pending[notify_qidx] is set at the next edge.
  - With notify_qidx>=NUM_Q, pending is unchanged and drop_cnt increments, saturating at 255.
  - Repeated notifies to an already-pending queue coalesce into one service.
- Eligible queue: pending[i] & q_en[i]. Pending bits of disabled queues are retained, not cleared.
- FSM states: IDLE, REQ, BUSY, IRQ.
  - IDLE: if drv_ok and any queue is eligible, pick the first eligible index searching from rr_ptr upward with wrap-around. At the edge: svc_qidx=index, svc_valid=1, pending[index]=0, rr_ptr=(index+1) mod NUM_Q, next=REQ. Otherwise stay in IDLE.
  - REQ: hold svc_valid and svc_qidx stable until svc_ready. On svc_valid&svc_ready, svc_valid=0 at that edge and next=BUSY.
  - BUSY: wait for done_valid.
    - If done_irq=1 and the granted queue's vector != NO_VECTOR: irq_vec=vector, irq_req=1, next=IRQ.
    - Otherwise next=IDLE.
    - done_valid in any other state is ignored.
  - IRQ: hold irq_req and irq_vec until irq_ack, then irq_req=0 and next=IDLE.
- Latency: notify on cycle N sets pending at edge N+1. With the FSM idle, svc_valid is high from edge N+2.
- Simultaneous events:
  - Notify for queue q on the same edge q is granted: pending[q] ends set, because the set wins over the grant-clear. q is serviced again later.
  - Notify is captured in every state and is never lost while busy.
- drv_ok deasserting mid-operation: the current transaction completes (REQ/BUSY/IRQ run to IDLE). IDLE then issues nothing until drv_ok returns; pending bits are held.
- q_msix_vec is sampled on the done_valid edge, not at grant.
- No combinational path from any input to any output.

Test Plan:
- Reset behaviour: rst_n low with notify_valid=1, qidx=1 -> pending=0 and svc_valid=0. Release rst_n, pulse notify qidx=1 at cycle N -> pending=3'b010 at N+1, svc_valid=1 with svc_qidx=1 at N+2, pending=0.
- Round-robin fairness: pending=3'b111, rr_ptr=0, engine accepts immediately and completes without irq -> grant order 0,1,2. Re-notify 0 and 2 while 2 is busy -> next grants are 0 then 2.
- Coalescing and simultaneous notify: five notifies to queue 2 while idle with drv_ok=0 -> drv_ok=1 gives exactly one service. A notify to q=0 on the same cycle q=0 is granted -> q=0 is serviced a second time.
- Interrupt path: vector for queue 1 = 16'h0002, done_irq=1 -> irq_req=1, irq_vec=16'h0002, held until irq_ack asserted 4 cycles later. Same test with vector 16'hFFFF -> irq_req never rises and the FSM returns to IDLE.
- Invalid and disabled queues: notify qidx=5 -> drop_cnt=1, pending unchanged; 300 such notifies -> drop_cnt=255. Notify q=0 with q_en[0]=0 -> pending[0]=1 but no grant until q_en[0]=1.
- Backpressure and reset mid-operation: svc_ready low for 10 cycles -> svc_valid and svc_qidx stable throughout. Assert rst_n low in BUSY -> all outputs immediately return to reset values.

Source files
------------

// File: rtl/virtio_notify_sched.sv
// virtio_notify_sched
//   Schedules virtqueue service between the virtio CSR block and the
//   virtqueue processing engine. Driver Queue Notify writes set a pending
//   bit per queue; one eligible queue at a time is offered to the engine in
//   round-robin order; on completion an MSI-X request is raised with that
//   queue's vector unless the vector is NO_VECTOR.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   notify_valid/_qidx      Queue Notify write pulse and queue index
//   drv_ok                  Device Status DRIVER_OK
//   q_en                    per-queue enable (queue address programmed)
//   q_msix_vec              per-queue MSI-X vectors, queue i at [i*VEC_W +: VEC_W]
//   svc_valid/_qidx/_ready  service request handshake to the engine
//   done_valid, done_irq    engine completion pulse and interrupt-needed flag
//   irq_req/_vec/_ack       MSI-X request handshake
//   pending                 per-queue pending bits
//   busy                    scheduler not idle
//   drop_cnt                saturating count of notifies to invalid queues
module virtio_notify_sched #(
  parameter int               NUM_Q     = 3,
  parameter int               QIDX_W    = 16,
  parameter int               VEC_W     = 16,
  parameter logic [VEC_W-1:0] NO_VECTOR = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   notify_valid,
  input  logic [QIDX_W-1:0]      notify_qidx,
  input  logic                   drv_ok,
  input  logic [NUM_Q-1:0]       q_en,
  input  logic [NUM_Q*VEC_W-1:0] q_msix_vec,
  output logic                   svc_valid,
  output logic [QIDX_W-1:0]      svc_qidx,
  input  logic                   svc_ready,
  input  logic                   done_valid,
  input  logic                   done_irq,
  output logic                   irq_req,
  output logic [VEC_W-1:0]       irq_vec,
  input  logic                   irq_ack,
  output logic [NUM_Q-1:0]       pending,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam logic [PTR_W:0] NUM_Q_W = (PTR_W+1)'(NUM_Q);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_IRQ  = 2'd3;

  logic [1:0]        state_r,     state_nxt_s;
  logic [PTR_W-1:0]  rr_ptr_r,    rr_ptr_nxt_s;
  logic [PTR_W-1:0]  grant_r,     grant_nxt_s;
  logic [NUM_Q-1:0]  pending_r,   pending_nxt_s;
  logic              svc_valid_r, svc_valid_nxt_s;
  logic [QIDX_W-1:0] svc_qidx_r,  svc_qidx_nxt_s;
  logic              irq_req_r,   irq_req_nxt_s;
  logic [VEC_W-1:0]  irq_vec_r,   irq_vec_nxt_s;
  logic              busy_r,      busy_nxt_s;
  logic [7:0]        drop_cnt_r,  drop_cnt_nxt_s;

  logic [NUM_Q-1:0]  eligible_s;
  logic              found_s;
  logic [PTR_W-1:0]  pick_s;
  logic [NUM_Q-1:0]  pick_oh_s;
  logic [VEC_W-1:0]  vec_sel_s;
  logic              notify_ok_s;
  logic [NUM_Q-1:0]  notify_oh_s;

  assign eligible_s = pending_r & q_en;

  // Round-robin search: first eligible queue at or after rr_ptr, with wrap.
  always_comb begin
    logic [PTR_W:0] sum_v;
    sum_v     = '0;
    found_s   = 1'b0;
    pick_s    = '0;
    pick_oh_s = '0;
    for (int k = 0; k < NUM_Q; k++) begin
      sum_v = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
      if (sum_v >= NUM_Q_W) begin
        sum_v = sum_v - NUM_Q_W;
      end else begin
        sum_v = sum_v;
      end
      if (!found_s && eligible_s[sum_v[PTR_W-1:0]]) begin
        found_s = 1'b1;
        pick_s  = sum_v[PTR_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < NUM_Q; i++) begin
      pick_oh_s[i] = found_s && (pick_s == PTR_W'(i));
    end
  end

  // Decode the notify write into a one-hot set mask; out-of-range indices give none.
  always_comb begin
    notify_ok_s = notify_valid && (notify_qidx < QIDX_W'(NUM_Q));
    notify_oh_s = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      notify_oh_s[i] = notify_ok_s && (notify_qidx == QIDX_W'(i));
    end
  end

  // Vector of the queue currently granted; read live at completion time.
  always_comb begin
    vec_sel_s = NO_VECTOR;
    for (int i = 0; i < NUM_Q; i++) begin
      if (grant_r == PTR_W'(i)) begin
        vec_sel_s = q_msix_vec[i*VEC_W +: VEC_W];
      end else begin
        vec_sel_s = vec_sel_s;
      end
    end
  end

  // Next-state computation for the scheduler FSM and all registered outputs.
  always_comb begin
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    grant_nxt_s     = grant_r;
    pending_nxt_s   = pending_r;
    svc_valid_nxt_s = svc_valid_r;
    svc_qidx_nxt_s  = svc_qidx_r;
    irq_req_nxt_s   = irq_req_r;
    irq_vec_nxt_s   = irq_vec_r;
    drop_cnt_nxt_s  = drop_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (drv_ok && found_s) begin
          svc_valid_nxt_s = 1'b1;
          svc_qidx_nxt_s  = QIDX_W'(pick_s);
          grant_nxt_s     = pick_s;
          pending_nxt_s   = pending_r & ~pick_oh_s;
          rr_ptr_nxt_s    = (pick_s == PTR_W'(NUM_Q - 1)) ? '0 : pick_s + PTR_W'(1);
          state_nxt_s     = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (svc_ready) begin
          svc_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_BUSY;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_BUSY: begin
        if (done_valid && done_irq && (vec_sel_s != NO_VECTOR)) begin
          irq_req_nxt_s = 1'b1;
          irq_vec_nxt_s = vec_sel_s;
          state_nxt_s   = ST_IRQ;
        end else if (done_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_IRQ: begin
        if (irq_ack) begin
          irq_req_nxt_s = 1'b0;
          state_nxt_s   = ST_IDLE;
        end else begin
          state_nxt_s = ST_IRQ;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        svc_valid_nxt_s = 1'b0;
        irq_req_nxt_s   = 1'b0;
      end
    endcase

    // Applied after the grant clear so a same-cycle notify keeps the queue pending.
    pending_nxt_s = pending_nxt_s | notify_oh_s;

    if (notify_valid && !notify_ok_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_nxt_s = drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      pending_r   <= '0;
      svc_valid_r <= 1'b0;
      svc_qidx_r  <= '0;
      irq_req_r   <= 1'b0;
      irq_vec_r   <= '0;
      busy_r      <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      grant_r     <= grant_nxt_s;
      pending_r   <= pending_nxt_s;
      svc_valid_r <= svc_valid_nxt_s;
      svc_qidx_r  <= svc_qidx_nxt_s;
      irq_req_r   <= irq_req_nxt_s;
      irq_vec_r   <= irq_vec_nxt_s;
      busy_r      <= busy_nxt_s;
      drop_cnt_r  <= drop_cnt_nxt_s;
    end
  end

  assign svc_valid = svc_valid_r;
  assign svc_qidx  = svc_qidx_r;
  assign irq_req   = irq_req_r;
  assign irq_vec   = irq_vec_r;
  assign pending   = pending_r;
  assign busy      = busy_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_virtio_notify_sched.sv
// tb_virtio_notify_sched
//   Self-checking bench for virtio_notify_sched: directed scenarios with
//   hand-computed expectations, then randomized traffic, all compared every
//   cycle against a behavioural model of the scheduler.
module tb_virtio_notify_sched;

  localparam int NUM_Q = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                notify_valid;
  logic [15:0]         notify_qidx;
  logic                drv_ok;
  logic [NUM_Q-1:0]    q_en;
  logic [NUM_Q*16-1:0] q_msix_vec;
  logic                svc_valid;
  logic [15:0]         svc_qidx;
  logic                svc_ready;
  logic                done_valid;
  logic                done_irq;
  logic                irq_req;
  logic [15:0]         irq_vec;
  logic                irq_ack;
  logic [NUM_Q-1:0]    pending;
  logic                busy;
  logic [7:0]          drop_cnt;

  logic [15:0] vec_tab [NUM_Q];
  assign q_msix_vec = {vec_tab[2], vec_tab[1], vec_tab[0]};

  always #5 clk = ~clk;

  virtio_notify_sched dut (
    .clk(clk), .rst_n(rst_n),
    .notify_valid(notify_valid), .notify_qidx(notify_qidx),
    .drv_ok(drv_ok), .q_en(q_en), .q_msix_vec(q_msix_vec),
    .svc_valid(svc_valid), .svc_qidx(svc_qidx), .svc_ready(svc_ready),
    .done_valid(done_valid), .done_irq(done_irq),
    .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .pending(pending), .busy(busy), .drop_cnt(drop_cnt)
  );

  // Behavioural model: where the scheduler is in a service transaction.
  typedef enum {M_IDLE, M_OFFERED, M_ENGINE, M_INTERRUPT} mphase_t;
  mphase_t        m_phase;
  bit [NUM_Q-1:0] m_pending;
  int             m_next_start;
  int             m_granted;
  bit             m_svc_valid;
  int             m_svc_qidx;
  bit             m_irq_req;
  int             m_irq_vec;
  int             m_drop;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_pending = '0; m_next_start = 0; m_granted = 0;
    m_svc_valid = 0; m_svc_qidx = 0; m_irq_req = 0; m_irq_vec = 0; m_drop = 0;
  endtask

  // One clock edge of the scheduler rules, using inputs as seen at the edge.
  task automatic model_step();
    int  q;
    bit  found;
    case (m_phase)
      M_IDLE: begin
        found = 0;
        if (drv_ok) begin
          for (int j = 0; j < NUM_Q; j++) begin
            q = (m_next_start + j) % NUM_Q;
            if (!found && m_pending[q] && q_en[q]) begin
              found = 1;
              m_granted = q;
            end
          end
        end
        if (found) begin
          m_svc_valid = 1;
          m_svc_qidx = m_granted;
          m_pending[m_granted] = 0;
          m_next_start = (m_granted + 1) % NUM_Q;
          m_phase = M_OFFERED;
        end
      end
      M_OFFERED: if (svc_ready) begin m_svc_valid = 0; m_phase = M_ENGINE; end
      M_ENGINE: if (done_valid) begin
        if (done_irq && vec_tab[m_granted] != 16'hFFFF) begin
          m_irq_req = 1; m_irq_vec = vec_tab[m_granted]; m_phase = M_INTERRUPT;
        end else begin
          m_phase = M_IDLE;
        end
      end
      M_INTERRUPT: if (irq_ack) begin m_irq_req = 0; m_phase = M_IDLE; end
      default: m_phase = M_IDLE;
    endcase
    if (notify_valid) begin
      if (notify_qidx < NUM_Q) m_pending[notify_qidx] = 1;
      else if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic compare_all();
    chk("svc_valid", svc_valid, m_svc_valid);
    chk("svc_qidx",  svc_qidx,  m_svc_qidx);
    chk("irq_req",   irq_req,   m_irq_req);
    chk("irq_vec",   irq_vec,   m_irq_vec);
    chk("pending",   pending,   m_pending);
    chk("busy",      busy,      m_phase != M_IDLE);
    chk("drop_cnt",  drop_cnt,  m_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic notify(input int q);
    notify_valid = 1'b1; notify_qidx = 16'(q);
    tick();
    notify_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; notify_valid = 1'b0; svc_ready = 1'b0; done_valid = 1'b0;
    done_irq = 1'b0; irq_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int exp_q);
    int n = 0;
    while (svc_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("grant_valid", svc_valid, 1);
    chk("grant_qidx", svc_qidx, exp_q);
  endtask

  task automatic accept();
    svc_ready = 1'b1;
    tick();
    svc_ready = 1'b0;
    chk("accept_svc_valid", svc_valid, 0);
    chk("accept_busy", busy, 1);
  endtask

  task automatic finish(input bit irq);
    done_valid = 1'b1; done_irq = irq;
    tick();
    done_valid = 1'b0; done_irq = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_Q; i++) vec_tab[i] = 16'hFFFF;
    model_reset();
    // Reset holds everything clear even with a notify present.
    rst_n = 1'b0; notify_valid = 1'b1; notify_qidx = 16'd1; drv_ok = 1'b1; q_en = 3'b111;
    svc_ready = 1'b0; done_valid = 1'b0; done_irq = 1'b0; irq_ack = 1'b0;
    tick();
    chk("rst_pending", pending, 0);
    chk("rst_svc_valid", svc_valid, 0);
    tick();
    notify_valid = 1'b0; rst_n = 1'b1;
    // Notify latency: pending at N+1, grant at N+2.
    notify(1);
    chk("lat_pending", pending, 3'b010);
    chk("lat_svc_idle", svc_valid, 0);
    tick();
    chk("lat_svc_valid", svc_valid, 1);
    chk("lat_svc_qidx", svc_qidx, 1);
    chk("lat_pending_clr", pending, 0);
    accept(); finish(0);

    // Round-robin order and re-notify while busy.
    reset_dut();
    drv_ok = 1'b0;
    notify(0); notify(1); notify(2);
    chk("rr_pending", pending, 3'b111);
    drv_ok = 1'b1;
    wait_grant(0); accept(); finish(0);
    wait_grant(1); accept(); finish(0);
    wait_grant(2); accept();
    notify(0); notify(2);
    finish(0);
    wait_grant(0); accept(); finish(0);
    wait_grant(2); accept(); finish(0);

    // Coalescing of repeated notifies.
    reset_dut();
    drv_ok = 1'b0;
    repeat (5) notify(2);
    chk("coal_pending", pending, 3'b100);
    drv_ok = 1'b1;
    wait_grant(2); accept(); finish(0);
    repeat (4) tick();
    chk("coal_no_second", svc_valid, 0);
    chk("coal_pending_clr", pending, 0);
    // Notify on the grant edge keeps the queue pending.
    drv_ok = 1'b0;
    notify(0);
    drv_ok = 1'b1; notify_valid = 1'b1; notify_qidx = 16'd0;
    tick();
    notify_valid = 1'b0;
    chk("sim_svc_valid", svc_valid, 1);
    chk("sim_svc_qidx", svc_qidx, 0);
    chk("sim_pending", pending, 3'b001);
    accept(); finish(0);
    wait_grant(0); accept(); finish(0);

    // Interrupt path with a real vector, then with NO_VECTOR.
    reset_dut();
    drv_ok = 1'b1; vec_tab[1] = 16'h0002;
    notify(1); wait_grant(1); accept(); finish(1);
    chk("irq_req_up", irq_req, 1);
    chk("irq_vec_val", irq_vec, 16'h0002);
    repeat (3) begin
      tick();
      chk("irq_hold", irq_req, 1);
      chk("irq_vec_hold", irq_vec, 16'h0002);
    end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("irq_released", irq_req, 0);
    chk("irq_idle", busy, 0);
    vec_tab[1] = 16'hFFFF;
    notify(1); wait_grant(1); accept(); finish(1);
    chk("novec_irq", irq_req, 0);
    chk("novec_idle", busy, 0);
    repeat (3) tick();
    chk("novec_irq_later", irq_req, 0);

    // Invalid queue indices and disabled queues.
    reset_dut();
    notify(5);
    chk("drop_one", drop_cnt, 8'd1);
    chk("drop_pending", pending, 0);
    repeat (299) notify(5);
    chk("drop_sat", drop_cnt, 8'd255);
    q_en = 3'b110; drv_ok = 1'b1;
    notify(0);
    repeat (5) tick();
    chk("dis_pending", pending, 3'b001);
    chk("dis_no_grant", svc_valid, 0);
    q_en = 3'b111;
    wait_grant(0); accept(); finish(0);

    // Backpressure, then asynchronous reset while BUSY.
    reset_dut();
    drv_ok = 1'b1;
    notify(2); wait_grant(2);
    repeat (10) begin
      tick();
      chk("bp_valid", svc_valid, 1);
      chk("bp_qidx", svc_qidx, 2);
    end
    accept();
    rst_n = 1'b0; model_reset();
    #1;
    chk("arst_svc_valid", svc_valid, 0);
    chk("arst_svc_qidx", svc_qidx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pending", pending, 0);
    chk("arst_irq_req", irq_req, 0);
    chk("arst_irq_vec", irq_vec, 0);
    chk("arst_drop", drop_cnt, 0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic against the model.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      drv_ok     = ($urandom_range(9) != 0);
      for (int i = 0; i < NUM_Q; i++) q_en[i] = ($urandom_range(6) != 0);
      notify_valid = ($urandom_range(4) < 2);
      if ($urandom_range(9) == 0) notify_qidx = 16'($urandom_range(65535));
      else notify_qidx = 16'($urandom_range(NUM_Q - 1));
      svc_ready  = $urandom_range(1);
      done_valid = ($urandom_range(9) < 3);
      done_irq   = $urandom_range(1);
      irq_ack    = ($urandom_range(9) < 4);
      if ($urandom_range(19) == 0) begin
        vec_tab[$urandom_range(NUM_Q - 1)] =
          ($urandom_range(2) == 0) ? 16'hFFFF : 16'($urandom_range(65534));
      end
      rst_n = ($urandom_range(499) != 0);
      tick();
      rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
